// File: rtl/axi3_gp_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : axi3_gp_bridge_if
// Description : AXI3 MAXIGP0 channels plus the single-outstanding out* bus
//               that the bridge drives towards the address-decoding
//               interconnect.
//               slave  modport : bridge side (AXI slave, out* bus master)
//               master modport : PS7 / interconnect side
// Ports       : AR, R, AW, W and B channels (32-bit data, 12-bit IDs,
//               4-bit lengths); outreq/outwr/outaddr/outwdata/outwstrb
//               towards the interconnect; outack/outerr/outrdata back.
// Revision    : 1.0  initial release
// ============================================================================
interface axi3_gp_bridge_if;
   // read address channel
   logic        axiarvalid;
   logic        axiarready;
   logic [31:0] axiaraddr;
   logic [3:0]  axiarlen;
   logic [1:0]  axiarburst;
   logic [11:0] axiarid;
   logic [2:0]  axiarsize;
   logic [1:0]  axiarlock;
   logic [2:0]  axiarprot;
   logic [3:0]  axiarcache;
   logic [3:0]  axiarqos;
   // read data channel
   logic        axirvalid;
   logic        axirready;
   logic [31:0] axirdata;
   logic [1:0]  axirresp;
   logic [11:0] axirid;
   logic        axirlast;
   // write address channel
   logic        axiawvalid;
   logic        axiawready;
   logic [31:0] axiawaddr;
   logic [3:0]  axiawlen;
   logic [1:0]  axiawburst;
   logic [11:0] axiawid;
   logic [2:0]  axiawsize;
   logic [1:0]  axiawlock;
   logic [2:0]  axiawprot;
   logic [3:0]  axiawcache;
   logic [3:0]  axiawqos;
   // write data channel
   logic        axiwvalid;
   logic        axiwready;
   logic [31:0] axiwdata;
   logic [3:0]  axiwstrb;
   logic [11:0] axiwid;
   logic        axiwlast;
   // write response channel
   logic        axibvalid;
   logic        axibready;
   logic [1:0]  axibresp;
   logic [11:0] axibid;
   // interconnect request/ack bus
   logic        outreq;
   logic        outwr;
   logic [31:0] outaddr;
   logic [31:0] outwdata;
   logic [3:0]  outwstrb;
   logic        outack;
   logic        outerr;
   logic [31:0] outrdata;

   modport slave (
      input  axiarvalid, axiaraddr, axiarlen, axiarburst, axiarid,
             axiarsize, axiarlock, axiarprot, axiarcache, axiarqos,
      output axiarready,
      output axirvalid, axirdata, axirresp, axirid, axirlast,
      input  axirready,
      input  axiawvalid, axiawaddr, axiawlen, axiawburst, axiawid,
             axiawsize, axiawlock, axiawprot, axiawcache, axiawqos,
      output axiawready,
      input  axiwvalid, axiwdata, axiwstrb, axiwid, axiwlast,
      output axiwready,
      output axibvalid, axibresp, axibid,
      input  axibready,
      output outreq, outwr, outaddr, outwdata, outwstrb,
      input  outack, outerr, outrdata
   );

   modport master (
      output axiarvalid, axiaraddr, axiarlen, axiarburst, axiarid,
             axiarsize, axiarlock, axiarprot, axiarcache, axiarqos,
      input  axiarready,
      input  axirvalid, axirdata, axirresp, axirid, axirlast,
      output axirready,
      output axiawvalid, axiawaddr, axiawlen, axiawburst, axiawid,
             axiawsize, axiawlock, axiawprot, axiawcache, axiawqos,
      input  axiawready,
      output axiwvalid, axiwdata, axiwstrb, axiwid, axiwlast,
      input  axiwready,
      input  axibvalid, axibresp, axibid,
      output axibready,
      input  outreq, outwr, outaddr, outwdata, outwstrb,
      output outack, outerr, outrdata
   );
endinterface
`default_nettype wire

// File: rtl/axi3_gp_bridge.sv
`default_nettype none
// ============================================================================
// Module      : axi3_gp_bridge
// Description : AXI3 slave terminating PS7 MAXIGP0. One AXI transaction at
//               a time; every beat becomes one request on the out* bus.
//               Bus errors map to SLVERR (2'b10); write errors are sticky
//               across the burst and reported once in B.
// Ports       : clk     - system clock (FCLKCLK[0])
//               rstn    - asynchronous active-low reset
//               axiaclk - copy of clk for MAXIGP0ACLK
//               bus     - AXI channels + out* bus (slave modport)
// Revision    : 1.0  initial release
// ============================================================================
module axi3_gp_bridge (
   input  wire              clk,
   input  wire              rstn,
   output logic             axiaclk,
   axi3_gp_bridge_if.slave  bus
);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_RADDR = 4'd1,
      S_RREQ  = 4'd2,
      S_RWAIT = 4'd3,
      S_RDATA = 4'd4,
      S_WADDR = 4'd5,
      S_WDATA = 4'd6,
      S_WREQ  = 4'd7,
      S_WWAIT = 4'd8,
      S_BRESP = 4'd9
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_last_was_read;
   logic [31:0] r_addr;
   logic [3:0]  r_len;
   logic [1:0]  r_burst;
   logic [11:0] r_id;
   logic [3:0]  r_cnt;
   logic        r_err;

   logic [31:0] r_rdata;
   logic [1:0]  r_rresp;
   logic        r_rlast;
   logic        r_arready;
   logic        r_awready;
   logic        r_wready;
   logic        r_rvalid;
   logic        r_bvalid;
   logic        r_outreq;
   logic        r_outwr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;

   logic        w_last_beat;
   logic        w_wrap_ok;
   logic [31:0] w_wrap_mask;
   logic [31:0] w_addr_inc;
   logic [31:0] w_addr_nxt;
   logic        w_unused;

   assign axiaclk = clk;

   // Sideband fields MAXIGP0 presents but this bridge has no use for.
   assign w_unused = ^{bus.axiarsize, bus.axiarlock, bus.axiarprot,
                       bus.axiarcache, bus.axiarqos,
                       bus.axiawsize, bus.axiawlock, bus.axiawprot,
                       bus.axiawcache, bus.axiawqos,
                       bus.axiwid, bus.axiwlast};

   assign w_last_beat = (r_cnt == r_len);

   // Next beat address. For the legal wrap lengths (1,3,7,15) the byte
   // mask ((len+1)<<2)-1 is simply {len, 2'b11}. addr[1:0] is carried
   // through untouched in every mode.
   always_comb begin
      w_wrap_mask = {26'd0, r_len, 2'b11};
      w_addr_inc  = {r_addr[31:2] + 30'd1, r_addr[1:0]};
      w_wrap_ok   = (r_len == 4'd1) || (r_len == 4'd3) ||
                    (r_len == 4'd7) || (r_len == 4'd15);
      case (r_burst)
         2'b00:   w_addr_nxt = r_addr;
         2'b10:   w_addr_nxt = w_wrap_ok ?
                               ((r_addr & ~w_wrap_mask) | (w_addr_inc & w_wrap_mask)) :
                               w_addr_inc;
         default: w_addr_nxt = w_addr_inc;
      endcase
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            // On a tie, serve whichever direction did not go last.
            if (bus.axiarvalid && (!bus.axiawvalid || !r_last_was_read))
               w_state_nxt = S_RADDR;
            else if (bus.axiawvalid)
               w_state_nxt = S_WADDR;
         end
         // Valid is held by the master, so ready is needed for one cycle only.
         S_RADDR: w_state_nxt = S_RREQ;
         S_RREQ:  w_state_nxt = S_RWAIT;
         S_RWAIT: if (bus.outack) w_state_nxt = S_RDATA;
         S_RDATA: if (bus.axirready) w_state_nxt = r_rlast ? S_IDLE : S_RREQ;
         S_WADDR: w_state_nxt = S_WDATA;
         S_WDATA: if (bus.axiwvalid) w_state_nxt = S_WREQ;
         S_WREQ:  w_state_nxt = S_WWAIT;
         S_WWAIT: if (bus.outack) w_state_nxt = w_last_beat ? S_BRESP : S_WDATA;
         S_BRESP: if (bus.axibready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register, registered handshake outputs and beat datapath.
   // Handshake flags are decoded from the next state so each is a flop.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state         <= S_IDLE;
         r_last_was_read <= 1'b0;
         r_addr          <= 32'd0;
         r_len           <= 4'd0;
         r_burst         <= 2'd0;
         r_id            <= 12'd0;
         r_cnt           <= 4'd0;
         r_err           <= 1'b0;
         r_rdata         <= 32'd0;
         r_rresp         <= 2'd0;
         r_rlast         <= 1'b0;
         r_arready       <= 1'b0;
         r_awready       <= 1'b0;
         r_wready        <= 1'b0;
         r_rvalid        <= 1'b0;
         r_bvalid        <= 1'b0;
         r_outreq        <= 1'b0;
         r_outwr         <= 1'b0;
         r_wdata         <= 32'd0;
         r_wstrb         <= 4'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_arready <= (w_state_nxt == S_RADDR);
         r_awready <= (w_state_nxt == S_WADDR);
         r_wready  <= (w_state_nxt == S_WDATA);
         r_rvalid  <= (w_state_nxt == S_RDATA);
         r_bvalid  <= (w_state_nxt == S_BRESP);
         r_outreq  <= (w_state_nxt == S_RREQ) || (w_state_nxt == S_WREQ);

         case (r_state)
            S_RADDR: begin
               r_addr          <= bus.axiaraddr;
               r_len           <= bus.axiarlen;
               r_burst         <= bus.axiarburst;
               r_id            <= bus.axiarid;
               r_cnt           <= 4'd0;
               r_err           <= 1'b0;
               r_outwr         <= 1'b0;
               r_last_was_read <= 1'b1;
            end
            S_WADDR: begin
               r_addr          <= bus.axiawaddr;
               r_len           <= bus.axiawlen;
               r_burst         <= bus.axiawburst;
               r_id            <= bus.axiawid;
               r_cnt           <= 4'd0;
               r_err           <= 1'b0;
               r_outwr         <= 1'b1;
               r_last_was_read <= 1'b0;
            end
            S_RWAIT: begin
               // outaddr only moves after the ack, keeping the request stable.
               if (bus.outack) begin
                  r_rdata <= bus.outrdata;
                  r_rresp <= bus.outerr ? 2'b10 : 2'b00;
                  r_rlast <= w_last_beat;
                  r_cnt   <= r_cnt + 4'd1;
                  r_addr  <= w_addr_nxt;
               end
            end
            S_WDATA: begin
               if (bus.axiwvalid) begin
                  r_wdata <= bus.axiwdata;
                  r_wstrb <= bus.axiwstrb;
               end
            end
            S_WWAIT: begin
               if (bus.outack) begin
                  r_err  <= r_err | bus.outerr;
                  r_cnt  <= r_cnt + 4'd1;
                  r_addr <= w_addr_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.axiarready = r_arready;
   assign bus.axiawready = r_awready;
   assign bus.axiwready  = r_wready;
   assign bus.axirvalid  = r_rvalid;
   assign bus.axirdata   = r_rdata;
   assign bus.axirresp   = r_rresp;
   assign bus.axirid     = r_id;
   assign bus.axirlast   = r_rlast;
   assign bus.axibvalid  = r_bvalid;
   assign bus.axibresp   = r_err ? 2'b10 : 2'b00;
   assign bus.axibid     = r_id;
   assign bus.outreq     = r_outreq;
   assign bus.outwr      = r_outwr;
   assign bus.outaddr    = r_addr;
   assign bus.outwdata   = r_wdata;
   assign bus.outwstrb   = r_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_axi3_gp_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axi3_gp_bridge
// Description : Directed self-checking bench for axi3_gp_bridge. A responder
//               process acks every out* request one cycle after the pulse,
//               returning queued data/err or (addr ^ KEY, addr == err_addr).
// Revision    : 1.0  initial release
// ============================================================================
module tb_axi3_gp_bridge;

   localparam logic [31:0] KEY = 32'h5A5A_0000;

   logic clk = 1'b0;
   logic rstn;
   logic axiaclk;

   axi3_gp_bridge_if bus();

   axi3_gp_bridge dut (
      .clk     (clk),
      .rstn    (rstn),
      .axiaclk (axiaclk),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // responder state
   logic        resp_en;
   logic        resp_ack;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        man_ack;
   logic [31:0] err_addr;
   logic [31:0] rsp_data_q[$];
   logic        rsp_err_q[$];
   logic [31:0] req_addr_q[$];
   logic [31:0] req_wr_q[$];
   logic [31:0] req_strb_q[$];
   logic [31:0] req_wdata_q[$];
   int          req_count = 0;

   assign bus.outack   = resp_en ? resp_ack   : man_ack;
   assign bus.outerr   = resp_en ? resp_err   : 1'b0;
   assign bus.outrdata = resp_en ? resp_rdata : 32'h0000_0011;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic sig_sel(input int s);
      case (s)
         0:       return bus.axiarready;
         1:       return bus.axiawready;
         2:       return bus.axiwready;
         3:       return bus.axirvalid;
         4:       return bus.axibvalid;
         default: return bus.outreq;
      endcase
   endfunction

   function automatic logic [31:0] req_field(input int f, input int i);
      if (i >= req_addr_q.size()) return 32'hxxxx_xxxx;
      case (f)
         0:       return req_addr_q[i];
         1:       return req_wr_q[i];
         2:       return req_strb_q[i];
         default: return req_wdata_q[i];
      endcase
   endfunction

   task automatic wait_sig(input int s, input string tag);
      int n = 0;
      while (sig_sel(s) !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) chk({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   // Records each request and acks it during the following cycle.
   initial begin
      resp_ack   = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = 32'd0;
      forever begin
         @(posedge clk); #1;
         resp_ack = 1'b0;
         if (bus.outreq === 1'b1) begin
            req_addr_q.push_back(bus.outaddr);
            req_wr_q.push_back({31'd0, bus.outwr});
            req_strb_q.push_back({28'd0, bus.outwstrb});
            req_wdata_q.push_back(bus.outwdata);
            req_count++;
            if (resp_en) begin
               @(posedge clk); #1;
               if (rsp_data_q.size() > 0) begin
                  resp_rdata = rsp_data_q.pop_front();
                  resp_err   = rsp_err_q.pop_front();
               end else begin
                  resp_rdata = bus.outaddr ^ KEY;
                  resp_err   = (bus.outaddr == err_addr);
               end
               resp_ack = 1'b1;
            end
         end
      end
   end

   task automatic ar_send(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b,
                          input logic [11:0] id, input string tag, output int base);
      bus.axiaraddr  = a;
      bus.axiarlen   = l;
      bus.axiarburst = b;
      bus.axiarid    = id;
      bus.axiarvalid = 1'b1;
      wait_sig(0, {tag, "_arready"});
      base = req_addr_q.size();
      @(posedge clk); #1;
      bus.axiarvalid = 1'b0;
      chk({tag, "_rd_lat"}, 32'(bus.outreq), 32'd1);
   endtask

   task automatic rd_txn(input string tag, input logic [31:0] a, input logic [3:0] l,
                         input logic [1:0] b, input logic [11:0] id, input int stall,
                         input logic [31:0] ea [4], input logic [31:0] ed [4],
                         input logic [1:0] er [4]);
      int base;
      int rc;
      ar_send(a, l, b, id, tag, base);
      for (int i = 0; i <= int'(l); i++) begin
         wait_sig(3, {tag, "_rvalid"});
         chk({tag, "_data"}, bus.axirdata, ed[i]);
         chk({tag, "_resp"}, 32'(bus.axirresp), 32'(er[i]));
         chk({tag, "_last"}, 32'(bus.axirlast), 32'(i == int'(l)));
         chk({tag, "_rid"},  32'(bus.axirid), 32'(id));
         if (i == stall) begin
            rc = req_count;
            repeat (5) begin @(posedge clk); #1; end
            chk({tag, "_stall_rvalid"}, 32'(bus.axirvalid), 32'd1);
            chk({tag, "_stall_noreq"}, 32'(req_count), 32'(rc));
         end
         bus.axirready = 1'b1;
         @(posedge clk); #1;
         bus.axirready = 1'b0;
      end
      chk({tag, "_nreq"}, 32'(req_addr_q.size() - base), 32'(int'(l) + 1));
      for (int i = 0; i <= int'(l); i++) begin
         chk({tag, "_addr"}, req_field(0, base + i), ea[i]);
         chk({tag, "_wr"},   req_field(1, base + i), 32'd0);
      end
   endtask

   task automatic wr_txn(input string tag, input logic [31:0] a, input logic [3:0] l,
                         input logic [1:0] b, input logic [11:0] id, input logic [31:0] wd,
                         input logic [3:0] st, input logic [31:0] ea [4], input logic [1:0] eb);
      int base;
      bus.axiawaddr  = a;
      bus.axiawlen   = l;
      bus.axiawburst = b;
      bus.axiawid    = id;
      bus.axiawvalid = 1'b1;
      wait_sig(1, {tag, "_awready"});
      base = req_addr_q.size();
      @(posedge clk); #1;
      bus.axiawvalid = 1'b0;
      chk({tag, "_wr_lat"}, 32'(bus.axiwready), 32'd1);
      for (int i = 0; i <= int'(l); i++) begin
         bus.axiwdata  = wd + 32'(i);
         bus.axiwstrb  = st;
         bus.axiwvalid = 1'b1;
         wait_sig(2, {tag, "_wready"});
         @(posedge clk); #1;
         bus.axiwvalid = 1'b0;
         chk({tag, "_req_lat"}, 32'(bus.outreq), 32'd1);
      end
      wait_sig(4, {tag, "_bvalid"});
      chk({tag, "_bresp"}, 32'(bus.axibresp), 32'(eb));
      chk({tag, "_bid"},   32'(bus.axibid), 32'(id));
      bus.axibready = 1'b1;
      @(posedge clk); #1;
      bus.axibready = 1'b0;
      chk({tag, "_nreq"}, 32'(req_addr_q.size() - base), 32'(int'(l) + 1));
      for (int i = 0; i <= int'(l); i++) begin
         chk({tag, "_addr"}, req_field(0, base + i), ea[i]);
         chk({tag, "_wr"},   req_field(1, base + i), 32'd1);
         chk({tag, "_strb"}, req_field(2, base + i), 32'(st));
         chk({tag, "_wdata"}, req_field(3, base + i), wd + 32'(i));
      end
   endtask

   function automatic logic [31:0] out_flags();
      return 32'({bus.axiarready, bus.axiawready, bus.axiwready, bus.axirvalid,
                  bus.axibvalid, bus.outreq, bus.outwr, bus.axirlast});
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      int base;
      bus.axiarvalid = 0; bus.axiaraddr = 0; bus.axiarlen = 0; bus.axiarburst = 0;
      bus.axiarid = 0; bus.axiarsize = 3'd2; bus.axiarlock = 0; bus.axiarprot = 0;
      bus.axiarcache = 0; bus.axiarqos = 0; bus.axirready = 0;
      bus.axiawvalid = 0; bus.axiawaddr = 0; bus.axiawlen = 0; bus.axiawburst = 0;
      bus.axiawid = 0; bus.axiawsize = 3'd2; bus.axiawlock = 0; bus.axiawprot = 0;
      bus.axiawcache = 0; bus.axiawqos = 0;
      bus.axiwvalid = 0; bus.axiwdata = 0; bus.axiwstrb = 0; bus.axiwid = 0;
      bus.axiwlast = 0; bus.axibready = 0;
      resp_en = 1'b1; man_ack = 1'b0; err_addr = 32'hFFFF_FFF0;
      rstn = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_flags",   out_flags(), 32'd0);
      chk("rst_outaddr", bus.outaddr, 32'd0);
      chk("rst_rdata",   bus.axirdata, 32'd0);
      chk("rst_ids",     32'({bus.axirid, bus.axibid, bus.axibresp, bus.axirresp}), 32'd0);
      rstn = 1'b1;
      @(posedge clk); #1;

      // simultaneous AR/AW out of reset: read first, then write
      s0 = req_wr_q.size();
      fork
         rd_txn("p1_rd", 32'h1000, 4'd0, 2'b01, 12'h001, -1,
                '{32'h1000, 0, 0, 0}, '{32'h5A5A_1000, 0, 0, 0}, '{2'd0, 2'd0, 2'd0, 2'd0});
         wr_txn("p1_wr", 32'h2000, 4'd0, 2'b01, 12'h002, 32'h1111_0000, 4'hF,
                '{32'h2000, 0, 0, 0}, 2'b00);
      join
      chk("p1_first",  req_field(1, s0),     32'd0);
      chk("p1_second", req_field(1, s0 + 1), 32'd1);

      // write went last, so the next tie goes to read again
      s0 = req_wr_q.size();
      fork
         rd_txn("p2_rd", 32'h1004, 4'd0, 2'b01, 12'h003, -1,
                '{32'h1004, 0, 0, 0}, '{32'h5A5A_1004, 0, 0, 0}, '{2'd0, 2'd0, 2'd0, 2'd0});
         wr_txn("p2_wr", 32'h2004, 4'd0, 2'b01, 12'h004, 32'h2222_0000, 4'hF,
                '{32'h2004, 0, 0, 0}, 2'b00);
      join
      chk("p2_first",  req_field(1, s0),     32'd0);
      chk("p2_second", req_field(1, s0 + 1), 32'd1);

      // lone read, then a tie must go to write
      rd_txn("lone_rd", 32'h1008, 4'd0, 2'b01, 12'h005, -1,
             '{32'h1008, 0, 0, 0}, '{32'h5A5A_1008, 0, 0, 0}, '{2'd0, 2'd0, 2'd0, 2'd0});
      s0 = req_wr_q.size();
      fork
         rd_txn("p3_rd", 32'h100C, 4'd0, 2'b01, 12'h006, -1,
                '{32'h100C, 0, 0, 0}, '{32'h5A5A_100C, 0, 0, 0}, '{2'd0, 2'd0, 2'd0, 2'd0});
         wr_txn("p3_wr", 32'h200C, 4'd0, 2'b01, 12'h007, 32'h3333_0000, 4'hF,
                '{32'h200C, 0, 0, 0}, 2'b00);
      join
      chk("p3_first",  req_field(1, s0),     32'd1);
      chk("p3_second", req_field(1, s0 + 1), 32'd0);

      // single read
      rsp_data_q.push_back(32'hDEAD_BEEF); rsp_err_q.push_back(1'b0);
      rd_txn("single_rd", 32'h4000_0010, 4'd0, 2'b01, 12'h5A5, -1,
             '{32'h4000_0010, 0, 0, 0}, '{32'hDEAD_BEEF, 0, 0, 0}, '{2'd0, 2'd0, 2'd0, 2'd0});

      // single write with bus error
      rsp_data_q.push_back(32'd0); rsp_err_q.push_back(1'b1);
      wr_txn("single_wr", 32'h4000_0204, 4'd0, 2'b01, 12'h0C3, 32'h1234_5678, 4'h3,
             '{32'h4000_0204, 0, 0, 0}, 2'b10);

      // INCR read burst, R stalled on beat 1, error on beat 2
      err_addr = 32'h108;
      rd_txn("incr_rd", 32'h100, 4'd3, 2'b01, 12'h011, 1,
             '{32'h100, 32'h104, 32'h108, 32'h10C},
             '{32'h5A5A_0100, 32'h5A5A_0104, 32'h5A5A_0108, 32'h5A5A_010C},
             '{2'd0, 2'd0, 2'd2, 2'd0});

      // WRAP write burst, error on beat 1 only
      err_addr = 32'h11C;
      wr_txn("wrap_wr", 32'h118, 4'd3, 2'b10, 12'h022, 32'hA000_0000, 4'hF,
             '{32'h118, 32'h11C, 32'h110, 32'h114}, 2'b10);
      err_addr = 32'hFFFF_FFF0;

      // WRAP with an illegal length behaves as INCR
      wr_txn("wrap_len2", 32'h118, 4'd2, 2'b10, 12'h023, 32'hB000_0000, 4'h5,
             '{32'h118, 32'h11C, 32'h120, 0}, 2'b00);

      // FIXED burst with misaligned low bits
      rd_txn("fixed_rd", 32'h202, 4'd1, 2'b00, 12'h044, -1,
             '{32'h202, 32'h202, 0, 0}, '{32'h5A5A_0202, 32'h5A5A_0202, 0, 0},
             '{2'd0, 2'd0, 2'd0, 2'd0});

      // INCR across the top of the address space keeps addr[1:0]
      rd_txn("wrap32_rd", 32'hFFFF_FFFE, 4'd1, 2'b11, 12'h055, -1,
             '{32'hFFFF_FFFE, 32'h0000_0002, 0, 0}, '{32'hA5A5_FFFE, 32'h5A5A_0002, 0, 0},
             '{2'd0, 2'd0, 2'd0, 2'd0});

      // reset during RWAIT of beat 2 of a 4-beat read
      resp_en = 1'b0;
      ar_send(32'h300, 4'd3, 2'b01, 12'h033, "rst_rd", base);
      @(posedge clk); #1;
      man_ack = 1'b1;
      @(posedge clk); #1;
      man_ack = 1'b0;
      wait_sig(3, "rst_rd_rvalid");
      chk("rst_rd_beat0", bus.axirdata, 32'h0000_0011);
      bus.axirready = 1'b1;
      @(posedge clk); #1;
      bus.axirready = 1'b0;
      chk("rst_rd_req2", 32'(bus.outreq), 32'd1);
      @(posedge clk); #1;
      #2;
      rstn = 1'b0;
      #1;
      chk("mid_rst_flags",   out_flags(), 32'd0);
      chk("mid_rst_outaddr", bus.outaddr, 32'd0);
      chk("mid_rst_rdata",   bus.axirdata, 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;
      // stale ack while idle
      man_ack = 1'b1;
      @(posedge clk); #1;
      man_ack = 1'b0;
      s0 = 0;
      repeat (3) begin
         @(posedge clk); #1;
         s0 = s0 | int'(out_flags());
      end
      chk("stale_ack_idle", 32'(s0), 32'd0);
      resp_en = 1'b1;
      rsp_data_q.push_back(32'hCAFE_F00D); rsp_err_q.push_back(1'b0);
      rd_txn("post_rst_rd", 32'h4000_0020, 4'd0, 2'b01, 12'h066, -1,
             '{32'h4000_0020, 0, 0, 0}, '{32'hCAFE_F00D, 0, 0, 0}, '{2'd0, 2'd0, 2'd0, 2'd0});

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
